// File: rtl/l3_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : l3_request_arbiter
// Description : Round-robin arbiter serialising L2 read/write requests onto
//               the single shared L3 request port. One transaction in flight;
//               a watchdog aborts transactions that L3 never completes.
// Revision    : 1.0 - initial release
// ============================================================================
module l3_request_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               l2_read_request,
  input  logic [NUM_REQ-1:0]               l2_write_request,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] l2_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    l2_write_data,
  output logic [NUM_REQ-1:0]               l2_grant,
  output logic [NUM_REQ-1:0]               l2_done,
  output logic                             l2_error,
  output logic [DATA_WIDTH-1:0]            l2_read_data,
  output logic                             l3_read_request,
  output logic                             l3_write_request,
  output logic [ADDRESS_WIDTH-1:0]         l3_address,
  output logic [DATA_WIDTH-1:0]            l3_write_data,
  input  logic                             l3_ready,
  input  logic [DATA_WIDTH-1:0]            l3_read_data
);

  // Requester id width and watchdog width (never below one bit).
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Watchdog value of the last permitted WAIT cycle.
  localparam logic [WDOG_W-1:0] c_wdog_last = WDOG_W'(TIMEOUT_CYCLES - 1);
  // Highest requester id, used for pointer wrap.
  localparam logic [ID_W-1:0]   c_id_last   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;

  logic [ID_W-1:0]          r_ptr;
  logic [ID_W-1:0]          r_id;
  logic                     r_op_write;
  logic                     r_error;
  logic [WDOG_W-1:0]        r_wdog;
  logic [ADDRESS_WIDTH-1:0] r_address;
  logic [DATA_WIDTH-1:0]    r_write_data;
  logic [DATA_WIDTH-1:0]    r_read_data;

  logic [NUM_REQ-1:0]       w_active;
  logic [ID_W-1:0]          w_cand [NUM_REQ];
  logic [ADDRESS_WIDTH-1:0] w_addr_slice [NUM_REQ];
  logic [DATA_WIDTH-1:0]    w_data_slice [NUM_REQ];
  logic                     w_any;
  logic [ID_W-1:0]          w_winner;
  logic                     w_winner_write;
  logic                     w_wdog_expired;
  logic [NUM_REQ-1:0]       w_id_onehot;
  logic [ID_W-1:0]          w_ptr_next;

  assign w_active       = l2_read_request | l2_write_request;
  assign w_wdog_expired = (r_wdog == c_wdog_last);
  assign w_id_onehot    = NUM_REQ'(1) << r_id;
  assign w_ptr_next     = (r_id == c_id_last) ? '0 : r_id + ID_W'(1);

  // Split the packed request buses into per-requester slices and build the
  // search order starting at the round-robin pointer.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign w_addr_slice[gi] = l2_address[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign w_data_slice[gi] = l2_write_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign w_cand[gi]       = ID_W'((int'(r_ptr) + gi) % NUM_REQ);
  end

  // Pick the first active requester at or above the pointer, wrapping.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any && w_active[w_cand[k]]) begin
        w_any    = 1'b1;
        w_winner = w_cand[k];
      end
    end
  end

  // A winner asserting both read and write is served as a write.
  assign w_winner_write = l2_write_request[w_winner];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_state_next     = r_state;
    l2_grant         = '0;
    l2_done          = '0;
    l2_error         = 1'b0;
    l3_read_request  = 1'b0;
    l3_write_request = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        l2_grant         = w_id_onehot;
        l3_read_request  = ~r_op_write;
        l3_write_request = r_op_write;
        w_state_next     = S_WAIT;
      end
      S_WAIT: begin
        l2_grant = w_id_onehot;
        if (l3_ready || w_wdog_expired) begin
          w_state_next = S_RESPOND;
        end
      end
      S_RESPOND: begin
        l2_grant     = w_id_onehot;
        l2_done      = w_id_onehot;
        l2_error     = r_error;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Transaction datapath: winner capture, watchdog, read-data capture, pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr        <= '0;
      r_id         <= '0;
      r_op_write   <= 1'b0;
      r_error      <= 1'b0;
      r_wdog       <= '0;
      r_address    <= '0;
      r_write_data <= '0;
      r_read_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id         <= w_winner;
            r_op_write   <= w_winner_write;
            r_address    <= w_addr_slice[w_winner];
            r_write_data <= w_data_slice[w_winner];
          end
        end
        S_ISSUE: begin
          r_wdog <= '0;
        end
        S_WAIT: begin
          if (l3_ready) begin
            // Writes complete without touching the returned-data register.
            if (!r_op_write) begin
              r_read_data <= l3_read_data;
            end
          end else if (w_wdog_expired) begin
            r_error <= 1'b1;
          end else begin
            r_wdog <= r_wdog + WDOG_W'(1);
          end
        end
        S_RESPOND: begin
          r_ptr   <= w_ptr_next;
          r_error <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign l2_read_data  = r_read_data;
  assign l3_address    = r_address;
  assign l3_write_data = r_write_data;

endmodule
`default_nettype wire

// File: tb/tb_l3_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_l3_request_arbiter
// Description : Self-checking bench for l3_request_arbiter. A transaction-level
//               reference (round-robin pick, WAIT length, timeout outcome,
//               returned data) predicts every observed output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l3_request_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    l2_read_request;
  logic [N-1:0]    l2_write_request;
  logic [N*AW-1:0] l2_address;
  logic [N*DW-1:0] l2_write_data;
  logic [N-1:0]    l2_grant;
  logic [N-1:0]    l2_done;
  logic            l2_error;
  logic [DW-1:0]   l2_read_data;
  logic            l3_read_request;
  logic            l3_write_request;
  logic [AW-1:0]   l3_address;
  logic [DW-1:0]   l3_write_data;
  logic            l3_ready;
  logic [DW-1:0]   l3_read_data;

  l3_request_arbiter #(
    .NUM_REQ       (N),
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .l2_read_request (l2_read_request),
    .l2_write_request(l2_write_request),
    .l2_address      (l2_address),
    .l2_write_data   (l2_write_data),
    .l2_grant        (l2_grant),
    .l2_done         (l2_done),
    .l2_error        (l2_error),
    .l2_read_data    (l2_read_data),
    .l3_read_request (l3_read_request),
    .l3_write_request(l3_write_request),
    .l3_address      (l3_address),
    .l3_write_data   (l3_write_data),
    .l3_ready        (l3_ready),
    .l3_read_data    (l3_read_data)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;

  // Reference state: round-robin pointer and last returned read data.
  int            m_ptr;
  logic [DW-1:0] m_rdata;

  // Requester-side stimulus state.
  logic [N-1:0]  req_rd;
  logic [N-1:0]  req_wr;
  logic [AW-1:0] addr [N];
  logic [DW-1:0] wdat [N];
  logic [N-1:0]  last_grant;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bus();
    l2_read_request  = req_rd;
    l2_write_request = req_wr;
    for (int i = 0; i < N; i++) begin
      l2_address[i*AW +: AW]    = addr[i];
      l2_write_data[i*DW +: DW] = wdat[i];
    end
  endtask

  // Round-robin reference: first requester at or above p, wrapping.
  function automatic int pick(input int p, input logic [N-1:0] m);
    for (int k = 0; k < N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, l2_grant, 0);
    chk({tag, "_done"}, l2_done, 0);
    chk({tag, "_error"}, l2_error, 0);
    chk({tag, "_rdata"}, l2_read_data, 0);
    chk({tag, "_strobes"}, {l3_read_request, l3_write_request}, 0);
    chk({tag, "_l3addr"}, l3_address, 0);
    chk({tag, "_l3wdata"}, l3_write_data, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      chk("idle_grant", l2_grant, 0);
      chk("idle_done", l2_done, 0);
      chk("idle_strobes", {l3_read_request, l3_write_request}, 0);
      l3_ready     = 1'($urandom_range(0, 1));
      l3_read_data = $urandom;
      tick();
    end
    l3_ready = 1'b0;
  endtask

  // One full transaction from IDLE back to IDLE. delay = WAIT cycle index in
  // which l3_ready rises (0 = first WAIT cycle); negative or >= T never rises.
  task automatic do_txn(input int delay, input logic [DW-1:0] rdata);
    int            w;
    logic          wr_op;
    logic          timed;
    int            nw;
    logic [N-1:0]  oh;
    logic [DW-1:0] exp_rd;
    w      = pick(m_ptr, req_rd | req_wr);
    wr_op  = req_wr[w];
    timed  = !(delay >= 0 && delay < T);
    nw     = timed ? T : delay + 1;
    oh     = N'(1) << w;
    exp_rd = (!wr_op && !timed) ? rdata : m_rdata;
    drive_bus();
    l3_ready     = 1'($urandom_range(0, 1));
    l3_read_data = $urandom;
    chk("idle_grant", l2_grant, 0);
    tick();
    // ISSUE
    chk("issue_grant", l2_grant, oh);
    chk("issue_rd_strobe", l3_read_request, !wr_op);
    chk("issue_wr_strobe", l3_write_request, wr_op);
    chk("issue_l3addr", l3_address, addr[w]);
    chk("issue_l3wdata", l3_write_data, wdat[w]);
    chk("issue_done", l2_done, 0);
    l3_ready     = 1'($urandom_range(0, 1));
    l3_read_data = $urandom;
    tick();
    // WAIT
    for (int n = 0; n < nw; n++) begin
      chk("wait_grant", l2_grant, oh);
      chk("wait_strobes", {l3_read_request, l3_write_request}, 0);
      chk("wait_done", l2_done, 0);
      l3_ready     = (n == delay);
      l3_read_data = (n == delay) ? rdata : $urandom;
      tick();
    end
    // RESPOND
    chk("resp_done", l2_done, oh);
    chk("resp_error", l2_error, timed);
    chk("resp_rdata", l2_read_data, exp_rd);
    chk("resp_grant", l2_grant, oh);
    chk("resp_l3addr", l3_address, addr[w]);
    last_grant = l2_grant;
    m_ptr      = (w + 1) % N;
    m_rdata    = exp_rd;
    req_rd[w]  = 1'b0;
    req_wr[w]  = 1'b0;
    drive_bus();
    l3_ready     = 1'($urandom_range(0, 1));
    l3_read_data = $urandom;
    tick();
    // Back in IDLE
    chk("post_grant", l2_grant, 0);
    chk("post_done", l2_done, 0);
    chk("post_error", l2_error, 0);
    chk("post_strobes", {l3_read_request, l3_write_request}, 0);
    chk("post_rdata", l2_read_data, m_rdata);
    l3_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int j;
    int dly;
    reset        = 1'b1;
    req_rd       = '0;
    req_wr       = '0;
    l3_ready     = 1'b0;
    l3_read_data = '0;
    for (int i = 0; i < N; i++) begin
      addr[i] = '0;
      wdat[i] = '0;
    end
    drive_bus();
    m_ptr   = 0;
    m_rdata = '0;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();
    chk_all_zero("after_reset");
    idle_cycles(2);

    // Single read from L2 2, data two WAIT cycles later (latency 4).
    addr[2] = 32'h0000_1040;
    wdat[2] = 32'h1111_2222;
    req_rd  = 4'b0100;
    do_txn(1, 32'hDEAD_BEEF);
    chk("read_grant", last_grant, 4'b0100);

    // Write from L2 1, ready in first WAIT cycle; read data must stay.
    addr[1] = 32'h0000_2000;
    wdat[1] = 32'hCAFE_0001;
    req_wr  = 4'b0010;
    do_txn(0, 32'h5555_AAAA);
    chk("write_rdata_kept", l2_read_data, 32'hDEAD_BEEF);

    // Serve L2 3 so the pointer wraps, then L2 1 and L2 3 contend.
    addr[3] = 32'h0000_3000;
    req_rd  = 4'b1000;
    do_txn(0, 32'h0BAD_F00D);
    addr[1] = 32'h0000_4100;
    addr[3] = 32'h0000_4300;
    req_rd  = 4'b1010;
    do_txn(0, 32'h1234_5678);
    chk("contention_winner", last_grant, 4'b0010);
    do_txn(0, 32'h8765_4321);
    chk("contention_second", last_grant, 4'b1000);

    // Round-robin with all four continuously active.
    for (int i = 0; i < N; i++) addr[i] = 32'h0001_0000 + i * 32'h10;
    req_rd = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      do_txn(0, $urandom);
      chk("rr_order", last_grant, N'(1) << (r % N));
      req_rd = 4'b1111;
    end
    req_rd = '0;
    req_wr = '0;
    drive_bus();
    idle_cycles(1);

    // Timeout: L3 never answers; late ready must be ignored.
    addr[0] = 32'h0000_0800;
    req_rd  = 4'b0001;
    do_txn(-1, 32'hFFFF_0000);
    idle_cycles(3);
    // Ready arriving in the last permitted WAIT cycle is not a timeout.
    req_rd  = 4'b0100;
    do_txn(T - 1, 32'h7777_8888);
    // Write that times out.
    req_wr  = 4'b1000;
    do_txn(-1, 32'h0);

    // Randomised traffic.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_rd[i] | req_wr[i]) && $urandom_range(0, 1) == 1) begin
          j = $urandom_range(0, 2);
          req_rd[i] = (j != 1);
          req_wr[i] = (j != 0);
          addr[i]   = $urandom;
          wdat[i]   = $urandom;
        end
      end
      if ((req_rd | req_wr) == 0) begin
        j = $urandom_range(0, N - 1);
        req_rd[j] = 1'b1;
        addr[j]   = $urandom;
      end
      dly = $urandom_range(0, 9);
      if (dly == 9) dly = -1;
      do_txn(dly, $urandom);
    end
    for (int d = 0; d < N && (req_rd | req_wr) != 0; d++) begin
      do_txn(0, $urandom);
    end

    // Reset mid-WAIT: pointer moved to 2 first so a stale pointer shows up.
    req_rd  = 4'b0000;
    req_wr  = 4'b0010;
    addr[1] = 32'h0000_5000;
    wdat[1] = 32'h0000_0051;
    do_txn(0, 32'h0);
    req_wr  = 4'b0000;
    req_rd  = 4'b0100;
    addr[2] = 32'h0000_6000;
    drive_bus();
    tick();
    tick();
    tick();
    chk("rst_pre_grant", l2_grant, 4'b0100);
    reset  = 1'b1;
    req_rd = '0;
    drive_bus();
    tick();
    chk_all_zero("rst_mid");
    reset = 1'b0;
    tick();
    chk_all_zero("rst_after");
    m_ptr   = 0;
    m_rdata = '0;
    idle_cycles(2);
    addr[1] = 32'h0000_7100;
    addr[3] = 32'h0000_7300;
    req_rd  = 4'b1010;
    do_txn(1, 32'hA5A5_5A5A);
    chk("rst_first_winner", last_grant, 4'b0010);
    req_rd = '0;
    drive_bus();
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l3_request_arbiter.md
# l3_request_arbiter

Round-robin arbiter between the four private L2 caches and the single shared L3 cache. Accepts read/write miss and write-back requests from up to NUM_REQ L2 instances, serialises them onto the single L3 request port, and returns read data and a one-cycle completion pulse to the winning L2. One transaction is outstanding at a time. A watchdog bounds the wait on L3.

## Interface
Parameters:
- NUM_REQ, 4: number of L2 requesters.
- ADDRESS_WIDTH, 32: address width, identical to cache_config.
- DATA_WIDTH, 32: data width, identical to cache_config.
- TIMEOUT_CYCLES, 1024: maximum WAIT cycles before the transaction is aborted.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high.
- l2_read_request  input  NUM_REQ  per-L2 read request; level, held until l2_done.
- l2_write_request  input  NUM_REQ  per-L2 write(-back) request; level, held until l2_done.
- l2_address  input  NUM_REQ*ADDRESS_WIDTH  packed; slice i belongs to L2 i.
- l2_write_data  input  NUM_REQ*DATA_WIDTH  packed; slice i belongs to L2 i.
- l2_grant  output  NUM_REQ  one-hot; indicates the L2 currently being served.
- l2_done  output  NUM_REQ  one-hot, one-cycle completion pulse.
- l2_error  output  1  high with l2_done when the transaction timed out.
- l2_read_data  output  DATA_WIDTH  read data; valid in the l2_done cycle and held until the next capture.
- l3_read_request  output  1  one-cycle read strobe to L3.
- l3_write_request  output  1  one-cycle write strobe to L3.
- l3_address  output  ADDRESS_WIDTH  latched address; stable from ISSUE through RESPOND.
- l3_write_data  output  DATA_WIDTH  latched write data; stable from ISSUE through RESPOND.
- l3_ready  input  1  L3 completion; sampled only in WAIT.
- l3_read_data  input  DATA_WIDTH  valid when l3_ready is high.

## Operation
The state machine has four states: IDLE, ISSUE, WAIT and RESPOND.

IDLE:
- A requester is active if (l2_read_request[i] | l2_write_request[i]).
- If any requester is active, select the first active index searching upward from ptr, wrapping modulo NUM_REQ.
- Latch the winner id, op, address slice and write-data slice.
- Go to ISSUE.
- If no requester is active, stay in IDLE.

ISSUE:
- Assert exactly one of l3_read_request or l3_write_request for this cycle only.
- Reset wdog to 0.
- Go to WAIT.

WAIT:
- If l3_ready is high: capture l3_read_data into l2_read_data (reads only; writes leave it unchanged) and go to RESPOND.
- Otherwise increment wdog.
- When wdog reaches TIMEOUT_CYCLES-1 with l3_ready low: set the error flag and go to RESPOND. l2_read_data is not updated.

RESPOND:
- Pulse l2_done[id] and drive l2_error = error flag.
- Set ptr = (id+1) mod NUM_REQ.
- Clear the error flag on exit.
- Go to IDLE.

Other rules:
- l2_grant[id] is high from ISSUE through RESPOND inclusive and is 0 in IDLE.
- Op encoding: if both read and write are high for the winner, it is treated as a write.
- Requests are not sampled in ISSUE, WAIT or RESPOND. Changes to a non-granted L2's request have no effect until IDLE.
- The winner must hold its request, address and data until l2_done, and must clear its request on the edge that ends the l2_done cycle. A request still high in the following IDLE is treated as a new request.
- Fairness: with all requesters continuously active, grants rotate 0,1,2,3,0,…

## Timing
- Reset values: state = IDLE, ptr = 0, wdog = 0, error flag = 0.
- All outputs are 0 during reset and on the first cycle after it: l2_grant, l2_done, l2_error, l2_read_data, l3_read_request, l3_write_request, l3_address, l3_write_data.
- Reset asserted mid-transaction abandons it. No l2_done is issued, and the L3 strobes drop on the next edge.
- Cycle-level latency:
  - Request sampled high at edge E0 (IDLE).
  - ISSUE with L3 strobe in cycle E0+1.
  - WAIT from E0+2.
  - l3_ready high in WAIT at cycle k gives l2_done in cycle k+1.
  - Minimum latency, request to l2_done: 3 cycles.
- l3_ready high during ISSUE, RESPOND or IDLE is ignored.
- Back-to-back transactions: the next ISSUE begins 2 cycles after RESPOND (RESPOND, then IDLE, then ISSUE).
- wdog is $clog2(TIMEOUT_CYCLES) bits wide. The timeout fires after exactly TIMEOUT_CYCLES WAIT cycles.

## Test plan
- Single read:
  - Stimulus: L2 2 reads address 0x0000_1040; L3 returns 0xDEAD_BEEF two WAIT cycles later.
  - Required: l3_read_request is a single pulse with l3_address = 0x1040; l2_grant = 4'b0100; l2_done = 4'b0100 with l2_read_data = 0xDEAD_BEEF and l2_error = 0; request-to-done latency is 4 cycles.
- Write:
  - Stimulus: L2 1 writes 0xCAFE_0001 to 0x2000; L3 responds with l3_ready in the first WAIT cycle.
  - Required: l3_write_request pulses with l3_write_data = 0xCAFE_0001; done after 3 cycles; l2_read_data is unchanged.
- Round-robin:
  - Stimulus: all 4 L2s continuously active; L3 responds in one cycle.
  - Required: grant order 0,1,2,3,0; no requester is served twice before all others are served.
- Contention after pointer move:
  - Stimulus: serve L2 3, then have L2 1 and L2 3 both request.
  - Required: L2 1 wins, because ptr has wrapped to 0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 8; L3 never raises l3_ready.
  - Required: l2_done and l2_error are high exactly 8 WAIT cycles after ISSUE; a late l3_ready is ignored.
- Reset mid-WAIT:
  - Stimulus: assert reset while in WAIT.
  - Required: all outputs are 0 on the next cycle; no l2_done is issued; ptr = 0; the first request after reset is served normally.
